// File: rtl/jop_dbg_seq_pkg.sv
// Shared types and defaults for the debug-port sequencer.
package jop_dbg_seq_pkg;

  localparam int unsigned JOP_DBG_SETTLE_DEF  = 4;
  localparam int unsigned JOP_DBG_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STALL  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/jop_dbg_seq_timer.sv
// Loadable down-counter with zero flag; shared by settle and access timeout.
module jop_dbg_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/jop_dbg_seq.sv
// Debug-port sequencer: stalls the core, settles, runs one strobe/ack access.
// Define JOP_DBG_SEQ_TIMEOUT_EN to bound the ack wait and report rsp_err.
module jop_dbg_seq
  import jop_dbg_seq_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned SETTLE  = JOP_DBG_SETTLE_DEF,
  parameter int unsigned TIMEOUT = JOP_DBG_TIMEOUT_DEF,
  parameter int unsigned CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic          cmd_hold,
  input  logic [AW-1:0] cmd_adr,
  input  logic [DW-1:0] cmd_dat,
  input  logic          release_i,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic          rsp_err,
  output logic          stalled_o,
  output logic          dbg_stall_o,
  output logic          dbg_stb_o,
  output logic          dbg_we_o,
  output logic [AW-1:0] dbg_adr_o,
  output logic [DW-1:0] dbg_dat_o,
  input  logic [DW-1:0] dbg_dat_i,
  input  logic          dbg_ack_i
);

  // Counter is loaded with N-1 so the zero flag is seen after exactly N cycles.
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TO_LD     = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_cmd_ready, r_rsp_valid, r_stall, r_stb;
  logic          r_cmd_we, r_cmd_hold, r_dbg_we;
  logic [AW-1:0] r_cmd_adr, r_dbg_adr;
  logic [DW-1:0] r_cmd_dat, r_dbg_dat, r_rsp_dat;

  logic          w_accept, w_ld_settle, w_go_access, w_zero;
  logic [CW-1:0] w_ld_val;
  logic          w_nxt_we;
  logic [AW-1:0] w_nxt_adr;
  logic [DW-1:0] w_nxt_dat;

  assign w_accept    = r_cmd_ready & cmd_valid;
  assign w_ld_settle = (r_state == ST_IDLE) & w_accept;
  assign w_go_access = ((r_state == ST_STALL) & w_zero) | ((r_state == ST_HOLD) & w_accept);
  assign w_ld_val    = w_ld_settle ? SETTLE_LD : TO_LD;

  jop_dbg_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ld_settle | w_go_access),
    .i_val  (w_ld_val),
    .o_zero (w_zero)
  );

  // From HOLD the access starts on the accept edge, so use the live command.
  always_comb begin
    w_nxt_we  = r_cmd_we;
    w_nxt_adr = r_cmd_adr;
    w_nxt_dat = r_cmd_we ? r_cmd_dat : '0;
    if (r_state == ST_HOLD) begin
      w_nxt_we  = cmd_we;
      w_nxt_adr = cmd_adr;
      w_nxt_dat = cmd_we ? cmd_dat : '0;
    end
  end

`ifdef JOP_DBG_SEQ_TIMEOUT_EN
  logic r_rsp_err;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_stall     <= 1'b0;
      r_stb       <= 1'b0;
      r_dbg_we    <= 1'b0;
      r_dbg_adr   <= '0;
      r_dbg_dat   <= '0;
      r_cmd_we    <= 1'b0;
      r_cmd_hold  <= 1'b0;
      r_cmd_adr   <= '0;
      r_cmd_dat   <= '0;
`ifdef JOP_DBG_SEQ_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_cmd_we    <= cmd_we;
        r_cmd_hold  <= cmd_hold;
        r_cmd_adr   <= cmd_adr;
        r_cmd_dat   <= cmd_dat;
        r_cmd_ready <= 1'b0;
      end
      if (w_go_access) begin
        r_stb     <= 1'b1;
        r_dbg_we  <= w_nxt_we;
        r_dbg_adr <= w_nxt_adr;
        r_dbg_dat <= w_nxt_dat;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_stall <= 1'b1;
            r_state <= ST_STALL;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_STALL: begin
          if (w_zero) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (dbg_ack_i) begin
            r_stb       <= 1'b0;
            r_dbg_we    <= 1'b0;
            r_dbg_adr   <= '0;
            r_dbg_dat   <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= r_dbg_we ? '0 : dbg_dat_i;
            r_state     <= ST_RESP;
`ifdef JOP_DBG_SEQ_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (w_zero) begin
            r_stb       <= 1'b0;
            r_dbg_we    <= 1'b0;
            r_dbg_adr   <= '0;
            r_dbg_dat   <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RESP;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_cmd_ready <= 1'b1;
`ifdef JOP_DBG_SEQ_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            if (r_cmd_hold) begin
              r_state <= ST_HOLD;
            end else begin
              r_stall <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_state <= ST_ACCESS;
          end else if (release_i) begin
            r_stall <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_dat     = r_rsp_dat;
  assign stalled_o   = r_stall;
  assign dbg_stall_o = r_stall;
  assign dbg_stb_o   = r_stb;
  assign dbg_we_o    = r_dbg_we;
  assign dbg_adr_o   = r_dbg_adr;
  assign dbg_dat_o   = r_dbg_dat;
`ifdef JOP_DBG_SEQ_TIMEOUT_EN
  assign rsp_err     = r_rsp_err;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_jop_dbg_seq.sv
// Bench for jop_dbg_seq: timestamp-based reference model plus directed scenarios.
module tb_jop_dbg_seq;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, cmd_hold = 1'b0, release_i = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0, dbg_dat_i = '0;
  logic        rsp_ready = 1'b0, dbg_ack_i = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, stalled_o, dbg_stall_o, dbg_stb_o, dbg_we_o;
  logic [31:0] rsp_dat, dbg_adr_o, dbg_dat_o;

  jop_dbg_seq #(.AW(32), .DW(32), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CW(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_hold(cmd_hold), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .release_i(release_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .stalled_o(stalled_o), .dbg_stall_o(dbg_stall_o), .dbg_stb_o(dbg_stb_o),
    .dbg_we_o(dbg_we_o), .dbg_adr_o(dbg_adr_o), .dbg_dat_o(dbg_dat_o),
    .dbg_dat_i(dbg_dat_i), .dbg_ack_i(dbg_ack_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: edge numbers since reset release; stb is high after edges t_stb..(t_r-1),
  // the response is valid from edge t_r until the handshake edge.
  int          cyc, m_e, t_stb, t_r;
  bit          m_active, m_held, m_we, m_hold, m_err;
  logic [31:0] m_adr, m_dat, m_rsp_dat;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0; m_active = 0; m_held = 0; t_r = -1; t_stb = 0; m_err = 0;
    end else begin
      m_e = cyc + 1;
      if (!m_active) begin
        if (cyc >= 1 && cmd_valid) begin
          m_active = 1;
          t_stb = m_held ? m_e : m_e + SETTLE;
          t_r = -1;
          m_we = cmd_we; m_hold = cmd_hold; m_adr = cmd_adr; m_dat = cmd_dat;
        end else if (m_held && release_i) begin
          m_held = 0;
        end
      end else if (t_r < 0) begin
        if (m_e > t_stb) begin
          if (dbg_ack_i) begin
            t_r = m_e; m_rsp_dat = m_we ? 32'h0 : dbg_dat_i; m_err = 0;
          end
`ifdef JOP_DBG_SEQ_TIMEOUT_EN
          else if (m_e - t_stb == TIMEOUT) begin
            t_r = m_e; m_rsp_dat = 32'h0; m_err = 1;
          end
`endif
        end
      end else if (m_e > t_r && rsp_ready) begin
        m_active = 0;
        m_held = m_hold;
      end
      cyc = m_e;
    end
  end

  always @(negedge clk) begin
    bit e_stb, e_rv;
    e_stb = m_active && t_r < 0 && cyc >= t_stb;
    e_rv  = m_active && t_r >= 0;
    chk("cmd_ready", cmd_ready, !m_active && cyc >= 1);
    chk("dbg_stall", dbg_stall_o, m_active || m_held);
    chk("stalled", stalled_o, m_active || m_held);
    chk("dbg_stb", dbg_stb_o, e_stb);
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_stb) begin
      chk("dbg_we", dbg_we_o, m_we);
      chk("dbg_adr", dbg_adr_o, m_adr);
      chk("dbg_dat", dbg_dat_o, m_we ? m_dat : 32'h0);
    end
    if (e_rv) begin
      chk("rsp_dat", rsp_dat, m_rsp_dat);
      chk("rsp_err", rsp_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit we, input bit hold, input bit rel,
                       input logic [31:0] adr, input logic [31:0] dat);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_we = we; cmd_hold = hold; cmd_adr = adr; cmd_dat = dat; release_i = rel;
    tick();
    cmd_valid = 0; release_i = 0;
  endtask

  task automatic wait_stb();
    int n = 0;
    while (!dbg_stb_o && n < 50) begin tick(); n++; end
    chk("stb_wait", dbg_stb_o, 1);
  endtask

  task automatic ack_now(input logic [31:0] d);
    dbg_ack_i = 1; dbg_dat_i = d;
    tick();
    dbg_ack_i = 0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_stall", dbg_stall_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    tick();
    chk("idle_ready", cmd_ready, 1);

    // Plain read with settle.
    issue(0, 0, 0, 32'h10, 32'h0);
    chk("rd_stall_p1", dbg_stall_o, 1);
    chk("rd_stb_p1", dbg_stb_o, 0);
    for (int k = 2; k <= 4; k++) begin tick(); chk("rd_stb_early", dbg_stb_o, 0); end
    tick();
    chk("rd_stb_p5", dbg_stb_o, 1);
    chk("rd_adr", dbg_adr_o, 32'h10);
    tick(); tick();
    ack_now(32'hCAFEBABE);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_dat", rsp_dat, 32'hCAFEBABE);
    chk("rd_rsp_err", rsp_err, 0);
    take_rsp();
    chk("rd_stall_after", dbg_stall_o, 0);

    // Write with hold, ack on the first strobe cycle, then a held read.
    issue(1, 1, 0, 32'h20, 32'h1234);
    wait_stb();
    chk("wr_dat", dbg_dat_o, 32'h1234);
    chk("wr_we", dbg_we_o, 1);
    ack_now(32'hDEAD0000);
    chk("wr_rsp_dat", rsp_dat, 32'h0);
    take_rsp();
    chk("hold_stall", dbg_stall_o, 1);
    chk("hold_ready", cmd_ready, 1);
    issue(0, 1, 0, 32'h24, 32'h0);
    chk("hold_stb_p1", dbg_stb_o, 1);
    chk("hold_adr", dbg_adr_o, 32'h24);
    chk("hold_rd_dat_o", dbg_dat_o, 32'h0);
    ack_now(32'h0BADF00D);
    chk("hold_rsp_dat", rsp_dat, 32'h0BADF00D);
    take_rsp();

    // Command and release together: command wins.
    issue(0, 1, 1, 32'h28, 32'h0);
    chk("race_stall", dbg_stall_o, 1);
    chk("race_stb", dbg_stb_o, 1);
    ack_now(32'h28282828);
    take_rsp();
    release_i = 1; tick(); release_i = 0;
    chk("rel_stall", dbg_stall_o, 0);
    chk("rel_ready", cmd_ready, 1);

    // Response backpressure.
    issue(0, 0, 0, 32'h30, 32'h0);
    wait_stb();
    ack_now(32'h13579BDF);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_dat", rsp_dat, 32'h13579BDF);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_stall", dbg_stall_o, 1);
      tick();
    end
    take_rsp();

`ifdef JOP_DBG_SEQ_TIMEOUT_EN
    issue(0, 0, 0, 32'h40, 32'h0);
    wait_stb();
    n = 0;
    while (dbg_stb_o && n < 50) begin n++; tick(); end
    chk("to_stb_len", n, 8);
    chk("to_err", rsp_err, 1);
    chk("to_dat", rsp_dat, 32'h0);
    take_rsp();
    issue(0, 0, 0, 32'h44, 32'h0);
    wait_stb();
    repeat (7) tick();
    ack_now(32'h77);
    chk("late8_err", rsp_err, 0);
    chk("late8_dat", rsp_dat, 32'h77);
    take_rsp();
`endif

    // Reset during an access.
    issue(1, 0, 0, 32'h50, 32'hAA);
    wait_stb();
    #2 rst = 0;
    #1;
    chk("mid_rst_stb", dbg_stb_o, 0);
    chk("mid_rst_stall", dbg_stall_o, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    tick(); tick();
    rst = 1;
    tick();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_rsp", rsp_valid, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
